word_serialiser: RTL and testbench

//  - Parallel-in/serial-out stage downstream of the N-bit bit-inverter stage.
//  - Accepts one N-bit word through a valid/ready handshake and shifts it out
//    one bit per clock with a per-bit valid flag and a start-of-frame marker.
//  - Runs on a single clock domain and drives the board-level serial pin/LED

---
 rtl/serialiser_pkg.sv | 14 +
 rtl/word_serialiser_counter.sv | 23 ++
 rtl/word_serialiser.sv | 123 ++++++++++++
 tb/tb_word_serialiser.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/serialiser_pkg.sv
// Shared types and constants for the word serialiser.
// SERIAL_PARITY_EN adds the PAR state used for the trailing even-parity bit.
package serialiser_pkg;

   localparam int N_MIN = 2;
   localparam int N_MAX = 32;

`ifdef SERIAL_PARITY_EN
   typedef enum logic [1:0] {IDLE, SHIFT, PAR} ser_state_t;
`else
   typedef enum logic [1:0] {IDLE, SHIFT} ser_state_t;
`endif

endpackage

// File: rtl/word_serialiser_counter.sv
// Synchronous-reset modulo-M counter with enable; tc flags the last count value.
module mod_counter #(
   parameter int M = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en,
   output logic [$clog2(M)-1:0] count,
   output logic                 tc
);

   localparam int CW = $clog2(M);

   assign tc = (count == CW'(M - 1));

   always_ff @(posedge clk) begin
      if (reset)
         count <= '0;
      else if (en)
         count <= tc ? '0 : count + CW'(1);
   end

endmodule

// File: rtl/word_serialiser.sv
// Parallel-in/serial-out stage: captures an N-bit word and shifts it out one bit per clock.
// Define SERIAL_PARITY_EN to append an even-parity bit after the data bits.
module word_serialiser
   import serialiser_pkg::*;
#(
   parameter int N         = 4,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N-1:0]         d,
   input  logic                 d_valid,
   output logic                 d_ready,
   output logic                 ser_out,
   output logic                 ser_valid,
   output logic                 ser_sof,
   output logic                 busy,
   output ser_state_t           state_dbg,
   output logic [$clog2(N)-1:0] count_dbg
);

   ser_state_t     state_q, state_d;
   logic [N-1:0]   sh_q, sh_d;
   logic           ser_out_d, ser_valid_d, ser_sof_d;
   logic           cnt_tc;
   logic           load_bit, shift_bit;
   logic [N-1:0]   load_rest, shift_rest;

   // Handshake: a word transfers on any edge where d_valid && d_ready; d_ready depends
   // only on state, so upstream must hold d/d_valid until it sees d_ready high.
   assign d_ready   = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign state_dbg = state_q;

   mod_counter #(.M(N)) u_bit_cnt (
      .clk   (clk),
      .reset (reset),
      .en    (state_q == SHIFT),
      .count (count_dbg),
      .tc    (cnt_tc)
   );

   generate
      if (MSB_FIRST) begin : g_msb_first
         assign load_bit   = d[N-1];
         assign load_rest  = {d[N-2:0], 1'b0};
         assign shift_bit  = sh_q[N-1];
         assign shift_rest = {sh_q[N-2:0], 1'b0};
      end else begin : g_lsb_first
         assign load_bit   = d[0];
         assign load_rest  = {1'b0, d[N-1:1]};
         assign shift_bit  = sh_q[0];
         assign shift_rest = {1'b0, sh_q[N-1:1]};
      end
   endgenerate

`ifdef SERIAL_PARITY_EN
   logic par_q;

   always_ff @(posedge clk) begin
      if (reset)
         par_q <= 1'b0;
      else if (d_valid && d_ready)
         par_q <= ^d;
   end
`endif

   // Bit 0 is driven straight from d on the accept edge, so the register keeps only the rest.
   always_comb begin
      state_d     = state_q;
      sh_d        = sh_q;
      ser_out_d   = 1'b0;
      ser_valid_d = 1'b0;
      ser_sof_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (d_valid) begin
               state_d     = SHIFT;
               sh_d        = load_rest;
               ser_out_d   = load_bit;
               ser_valid_d = 1'b1;
               ser_sof_d   = 1'b1;
            end
         end
         SHIFT: begin
            if (cnt_tc) begin
`ifdef SERIAL_PARITY_EN
               state_d     = PAR;
               ser_out_d   = par_q;
               ser_valid_d = 1'b1;
`else
               state_d     = IDLE;
`endif
            end else begin
               sh_d        = shift_rest;
               ser_out_d   = shift_bit;
               ser_valid_d = 1'b1;
            end
         end
`ifdef SERIAL_PARITY_EN
         PAR: state_d = IDLE;
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         sh_q      <= '0;
         ser_out   <= 1'b0;
         ser_valid <= 1'b0;
         ser_sof   <= 1'b0;
      end else begin
         state_q   <= state_d;
         sh_q      <= sh_d;
         ser_out   <= ser_out_d;
         ser_valid <= ser_valid_d;
         ser_sof   <= ser_sof_d;
      end
   end

endmodule

// File: tb/tb_word_serialiser.sv
// Scoreboard bench for word_serialiser: LSB-first N=4, MSB-first N=4 and MSB-first N=8.
// Build with SERIAL_PARITY_EN defined to cover the parity frame.
`timescale 1ns/1ps
module tb_word_serialiser;
   import serialiser_pkg::*;

`ifdef SERIAL_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] d0 = '0, d1 = '0;
   logic [7:0] d2 = '0;
   logic [2:0] dv = '0;
   logic [2:0] rdy, sv, sof, so, busy;
   ser_state_t st0, st1, st2;
   logic [1:0] cnt0, cnt1;
   logic [2:0] cnt2;

   logic [1:0] exp_q0[$], exp_q1[$], exp_q2[$];
   int n_checks = 0, n_fail = 0, cyc = 0, acc_cyc = 0;

   // clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   word_serialiser #(.N(4), .MSB_FIRST(1'b0)) u_dut0 (
      .clk(clk), .reset(reset), .d(d0), .d_valid(dv[0]), .d_ready(rdy[0]),
      .ser_out(so[0]), .ser_valid(sv[0]), .ser_sof(sof[0]), .busy(busy[0]),
      .state_dbg(st0), .count_dbg(cnt0));
   word_serialiser #(.N(4), .MSB_FIRST(1'b1)) u_dut1 (
      .clk(clk), .reset(reset), .d(d1), .d_valid(dv[1]), .d_ready(rdy[1]),
      .ser_out(so[1]), .ser_valid(sv[1]), .ser_sof(sof[1]), .busy(busy[1]),
      .state_dbg(st1), .count_dbg(cnt1));
   word_serialiser #(.N(8), .MSB_FIRST(1'b1)) u_dut2 (
      .clk(clk), .reset(reset), .d(d2), .d_valid(dv[2]), .d_ready(rdy[2]),
      .ser_out(so[2]), .ser_valid(sv[2]), .ser_sof(sof[2]), .busy(busy[2]),
      .state_dbg(st2), .count_dbg(cnt2));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // scoreboard monitor: one entry {sof, bit} per valid serial cycle
   task automatic mon(input int id, input logic o, input logic s);
      logic [1:0] e;
      int sz;
      sz = (id == 0) ? exp_q0.size() : (id == 1) ? exp_q1.size() : exp_q2.size();
      check($sformatf("dut%0d_bit_expected", id), 32'(sz != 0), 32'd1);
      if (sz != 0) begin
         case (id)
            0:       e = exp_q0.pop_front();
            1:       e = exp_q1.pop_front();
            default: e = exp_q2.pop_front();
         endcase
         check($sformatf("dut%0d_ser_out", id), 32'(o), 32'(e[0]));
         check($sformatf("dut%0d_ser_sof", id), 32'(s), 32'(e[1]));
      end
   endtask

   always @(negedge clk) begin
      if (sv[0]) mon(0, so[0], sof[0]);
      if (sv[1]) mon(1, so[1], sof[1]);
      if (sv[2]) mon(2, so[2], sof[2]);
   end

   task automatic push(input int id, input logic [1:0] e);
      case (id)
         0:       exp_q0.push_back(e);
         1:       exp_q1.push_back(e);
         default: exp_q2.push_back(e);
      endcase
   endtask

   // driver: seq[i] is the i-th bit expected on the wire, par the expected parity bit
   task automatic send(input int id, input logic [7:0] w, input logic [7:0] seq, input logic par);
      int k = 0;
      int nb = (id == 2) ? 8 : 4;
      case (id)
         0:       d0 = w[3:0];
         1:       d1 = w[3:0];
         default: d2 = w;
      endcase
      dv[id] = 1'b1;
      while (!rdy[id] && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      check($sformatf("dut%0d_ready_timeout", id), 32'(k < 100), 32'd1);
      for (int i = 0; i < nb; i++) push(id, {i == 0, seq[i]});
`ifdef SERIAL_PARITY_EN
      push(id, {1'b0, par});
`endif
      @(posedge clk); #1;
      acc_cyc = cyc;
      dv[id] = 1'b0;
   endtask

   task automatic wait_idle(input int id);
      int k = 0;
      while (busy[id] && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      check($sformatf("dut%0d_idle_timeout", id), 32'(busy[id]), 32'd0);
   endtask

   int a0;

   initial begin : stimulus
      // reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_ser_valid", 32'(sv), 32'd0);
      check("rst_ser_out", 32'(so), 32'd0);
      check("rst_ser_sof", 32'(sof), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_d_ready", 32'(rdy), 32'd7);
      check("rst_state", 32'(st0), 32'(IDLE));
      reset = 1'b0;

      // LSB first 0101 -> 1,0,1,0 with exact frame timing
      send(0, 8'h05, 8'h05, 1'b0);
      for (int i = 0; i < 4 + PB; i++) begin
         check("t2_busy_in_frame", 32'(busy[0]), 32'd1);
         check("t2_valid_in_frame", 32'(sv[0]), 32'd1);
         if (i < 4) check("t2_count", 32'(cnt0), 32'(i));
         @(posedge clk); #1;
      end
      check("t2_busy_after", 32'(busy[0]), 32'd0);
      check("t2_ready_after", 32'(rdy[0]), 32'd1);
      check("t2_valid_after", 32'(sv[0]), 32'd0);

      // MSB first: 1100 -> 1,1,0,0 and A5 -> 1,0,1,0,0,1,0,1
      send(1, 8'h0C, 8'h03, 1'b0);
      send(2, 8'hA5, 8'hA5, 1'b0);
      wait_idle(1);
      wait_idle(2);

      // back-to-back with d changing while busy
      send(0, 8'h03, 8'h03, 1'b0);
      a0 = acc_cyc;
      send(0, 8'h0C, 8'h0C, 1'b0);
      check("t4_accept_spacing", 32'(acc_cyc - a0), 32'(5 + PB));
      wait_idle(0);

      // parity words: 0111 -> parity 1, 0101 -> parity 0
      send(0, 8'h07, 8'h07, 1'b1);
      send(0, 8'h05, 8'h05, 1'b0);
      wait_idle(0);

      // reset at bit 2 with d_valid held high through the reset
      send(0, 8'h0B, 8'h0B, 1'b1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("t6_bit2_count", 32'(cnt0), 32'd2);
      d0 = 4'h6;
      dv[0] = 1'b1;
      reset = 1'b1;
      @(posedge clk); #1;
      exp_q0.delete();
      check("t6_abort_valid", 32'(sv[0]), 32'd0);
      check("t6_abort_busy", 32'(busy[0]), 32'd0);
      check("t6_abort_out", 32'(so[0]), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      dv[0] = 1'b0;
      @(posedge clk); #1;
      check("t6_release_ready", 32'(rdy[0]), 32'd1);
      check("t6_release_busy", 32'(busy[0]), 32'd0);
      check("t6_release_count", 32'(cnt0), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check("t6_no_resume", 32'(busy[0]), 32'd0);
      send(0, 8'h06, 8'h06, 1'b0);
      wait_idle(0);

      repeat (4) @(posedge clk);
      #1;
      check("queues_drained", 32'(exp_q0.size() + exp_q1.size() + exp_q2.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
